// File: rtl/dp_mc_param_if.sv
// Memory-side bus of the multi-cycle datapath: one req/ack transaction at a time,
// with registered address, write data and direction.
interface dp_mc_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 26
);
    logic                  MEM_REQ;
    logic                  MEM_WE;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [DATA_WIDTH-1:0] MEM_WDATA;
    logic                  MEM_ACK;
    logic [DATA_WIDTH-1:0] MEM_RDATA;

    modport master (
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_ACK, MEM_RDATA
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_ACK, MEM_RDATA
    );
endinterface

// File: rtl/dp_mc_param.sv
// Parametrised multi-cycle datapath (PC, IR, SP, MDR, register file, ALU) steered by
// per-step control inputs, with a req/ack memory port that stalls the datapath.
//
//   state  | meaning
//   S_IDLE | no transaction pending; control loads and new requests accepted
//   S_WAIT | transaction pending; MEM_REQ/BUSY high, architectural state frozen
module dp_mc_param #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    REG_COUNT  = 32,
    parameter int                    ADDR_WIDTH = 26,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = 'h00001000,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = 'h03FFFFFF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PC_LOAD,
    input  logic [1:0]            PC_SEL,
    input  logic                  IR_LOAD,
    input  logic                  R1_SEL,
    input  logic                  RF_WE,
    input  logic [1:0]            WA_SEL,
    input  logic [1:0]            WD_SEL,
    input  logic                  SP_LOAD,
    input  logic                  OP1_SEL,
    input  logic [2:0]            OP2_SEL,
    input  logic [3:0]            ALU_OP,
    input  logic [1:0]            MA_SEL,
    input  logic                  MD_SEL,
    input  logic                  MEM_RD,
    input  logic                  MEM_WR,
    dp_mc_param_if.master         mem,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ZERO,
    output logic [DATA_WIDTH-1:0] PC_OUT,
    output logic [31:0]           IR_OUT
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int RW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int SW = $clog2(DATA_WIDTH);
    localparam logic [RW-1:0] LAST_REG = RW'(REG_COUNT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state, state_nxt;

    logic [DW-1:0] pc, sp, mdr;
    logic [31:0]   ir;
    logic [DW-1:0] regs [REG_COUNT];
    logic          done_q;

    logic          stall, start, ack_take;
    logic [RW-1:0] r1_addr, r2_addr, wa;
    logic [DW-1:0] r1_val, r2_val, wd;
    logic [DW-1:0] sext_imm, zext_imm, pc_inc, pc_nxt;
    logic [DW-1:0] op1, op2, alu;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;

    assign stall    = (state == S_WAIT);
    assign start    = !stall && (MEM_RD || MEM_WR);
    assign ack_take = stall && mem.MEM_ACK;

    assign sext_imm = {{(DW-16){ir[15]}}, ir[15:0]};
    assign zext_imm = {{(DW-16){1'b0}}, ir[15:0]};
    assign pc_inc   = pc + 1'b1;

    // Register 0 is hardwired: reads are masked here, writes are dropped below.
    assign r1_addr = R1_SEL ? '0 : ir[21 +: RW];
    assign r2_addr = ir[16 +: RW];
    assign r1_val  = (r1_addr == '0) ? '0 : regs[r1_addr];
    assign r2_val  = (r2_addr == '0) ? '0 : regs[r2_addr];

    always_comb begin
        wa = '0;
        case (WA_SEL)
            2'd0:    wa = ir[16 +: RW];
            2'd1:    wa = ir[11 +: RW];
            2'd2:    wa = LAST_REG;
            default: wa = '0;
        endcase
    end

    always_comb begin
        op1 = OP1_SEL ? sp : r1_val;
        op2 = '0;
        case (OP2_SEL)
            3'd0:    op2 = r2_val;
            3'd1:    op2 = sext_imm;
            3'd2:    op2 = zext_imm;
            3'd3:    op2 = {{(DW-5){1'b0}}, ir[10:6]};
            3'd4:    op2 = {{(DW-1){1'b0}}, 1'b1};
            default: op2 = '0;
        endcase
    end

    always_comb begin
        alu = '0;
        case (ALU_OP)
            4'd0:    alu = op1 + op2;
            4'd1:    alu = op1 - op2;
            4'd2:    alu = op1 & op2;
            4'd3:    alu = op1 | op2;
            4'd4:    alu = ~(op1 | op2);
            4'd5:    alu = op1 << op2[SW-1:0];
            4'd6:    alu = op1 >> op2[SW-1:0];
            4'd7:    alu = {{(DW-1){1'b0}}, ($signed(op1) < $signed(op2))};
            default: alu = '0;
        endcase
    end

    assign ZERO = (alu == '0);

    always_comb begin
        wd = '0;
        case (WD_SEL)
            2'd0:    wd = alu;
            2'd1:    wd = mdr;
            2'd2:    wd = {ir[15:0], {(DW-16){1'b0}}};
            default: wd = pc_inc;
        endcase
    end

    always_comb begin
        pc_nxt = pc_inc;
        case (PC_SEL)
            2'd0:    pc_nxt = pc_inc;
            2'd1:    pc_nxt = pc_inc + sext_imm;
            2'd2:    pc_nxt = r1_val;
            default: pc_nxt = {{(DW-26){1'b0}}, ir[25:0]};
        endcase
    end

    // Address is truncated per source so unused upper bits never enter the mux.
    always_comb begin
        ma = '0;
        case (MA_SEL)
            2'd0:    ma = alu[AW-1:0];
            2'd1:    ma = sp[AW-1:0];
            2'd2:    ma = pc[AW-1:0];
            default: ma = '0;
        endcase
        md = MD_SEL ? r1_val : r2_val;
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (MEM_RD || MEM_WR) state_nxt = S_WAIT;
            S_WAIT:  if (mem.MEM_ACK)      state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc            <= PC_RESET;
            sp            <= SP_RESET;
            ir            <= '0;
            mdr           <= '0;
            done_q        <= 1'b0;
            mem.MEM_WE    <= 1'b0;
            mem.MEM_ADDR  <= '0;
            mem.MEM_WDATA <= '0;
        end else begin
            if (!stall) begin
                if (PC_LOAD) pc <= pc_nxt;
                if (SP_LOAD) sp <= alu;
                if (IR_LOAD) ir <= mdr[31:0];
            end
            // Request fields capture pre-edge values, alongside any same-edge loads.
            if (start) begin
                mem.MEM_ADDR  <= ma;
                mem.MEM_WDATA <= md;
                mem.MEM_WE    <= MEM_WR;
            end
            if (ack_take && !mem.MEM_WE) mdr <= mem.MEM_RDATA;
            done_q <= ack_take;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (RF_WE && !stall && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign mem.MEM_REQ = stall;
    assign BUSY        = stall;
    assign DONE        = done_q;
    assign PC_OUT      = pc;
    assign IR_OUT      = ir;
endmodule

// File: tb/tb_dp_mc_param.sv
// Directed bench for dp_mc_param: a 32-bit instance exercised through fetch, ALU,
// stack and memory-handshake steps, plus a 64-bit / 8-register instance.
module tb_dp_mc_param;
    typedef struct packed {
        logic       pc_load;
        logic [1:0] pc_sel;
        logic       ir_load;
        logic       r1_sel;
        logic       rf_we;
        logic [1:0] wa_sel;
        logic [1:0] wd_sel;
        logic       sp_load;
        logic       op1_sel;
        logic [2:0] op2_sel;
        logic [3:0] alu_op;
        logic [1:0] ma_sel;
        logic       md_sel;
        logic       mem_rd;
        logic       mem_wr;
    } ctrl_t;

    typedef struct {
        logic        we;
        logic [25:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic  CLK = 1'b0;
    logic  RST = 1'b0;
    ctrl_t c1, c2;
    txn_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;

    logic        busy1, done1, zero1;
    logic [31:0] pc1, ir1;
    logic        busy2, done2, zero2;
    logic [63:0] pc2;
    logic [31:0] ir2;

    dp_mc_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(26)) mem1 ();
    dp_mc_param_if #(.DATA_WIDTH(64), .ADDR_WIDTH(48)) mem2 ();

    always #5 CLK = ~CLK;

    dp_mc_param dut1 (
        .CLK(CLK), .RST(RST),
        .PC_LOAD(c1.pc_load), .PC_SEL(c1.pc_sel), .IR_LOAD(c1.ir_load), .R1_SEL(c1.r1_sel),
        .RF_WE(c1.rf_we), .WA_SEL(c1.wa_sel), .WD_SEL(c1.wd_sel), .SP_LOAD(c1.sp_load),
        .OP1_SEL(c1.op1_sel), .OP2_SEL(c1.op2_sel), .ALU_OP(c1.alu_op), .MA_SEL(c1.ma_sel),
        .MD_SEL(c1.md_sel), .MEM_RD(c1.mem_rd), .MEM_WR(c1.mem_wr), .mem(mem1.master),
        .BUSY(busy1), .DONE(done1), .ZERO(zero1), .PC_OUT(pc1), .IR_OUT(ir1)
    );

    dp_mc_param #(.DATA_WIDTH(64), .REG_COUNT(8), .ADDR_WIDTH(48)) dut2 (
        .CLK(CLK), .RST(RST),
        .PC_LOAD(c2.pc_load), .PC_SEL(c2.pc_sel), .IR_LOAD(c2.ir_load), .R1_SEL(c2.r1_sel),
        .RF_WE(c2.rf_we), .WA_SEL(c2.wa_sel), .WD_SEL(c2.wd_sel), .SP_LOAD(c2.sp_load),
        .OP1_SEL(c2.op1_sel), .OP2_SEL(c2.op2_sel), .ALU_OP(c2.alu_op), .MA_SEL(c2.ma_sel),
        .MD_SEL(c2.md_sel), .MEM_RD(c2.mem_rd), .MEM_WR(c2.mem_wr), .mem(mem2.master),
        .BUSY(busy2), .DONE(done2), .ZERO(zero2), .PC_OUT(pc2), .IR_OUT(ir2)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic we, input logic [25:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        sb_q.push_back(t);
    endtask

    // Called in the first WAIT cycle: the latched request must match the oldest expectation.
    task automatic sb_check();
        txn_t t;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty: observed request with no expected entry");
        end
        if (sb_q.size() != 0) begin
            t = sb_q.pop_front();
            chk("mem_req", mem1.MEM_REQ, 1);
            chk("mem_addr", mem1.MEM_ADDR, t.addr);
            chk("mem_we", mem1.MEM_WE, t.we);
            if (t.we) chk("mem_wdata", mem1.MEM_WDATA, t.wdata);
        end
    endtask

    task automatic do_txn(input int waits, input logic [31:0] rdata);
        sb_check();
        for (int i = 0; i < waits; i++) begin
            chk("busy_wait", busy1, 1);
            tick();
        end
        mem1.MEM_ACK   = 1'b1;
        mem1.MEM_RDATA = rdata;
        chk("busy_ack", busy1, 1);
        tick();
        mem1.MEM_ACK   = 1'b0;
        mem1.MEM_RDATA = '0;
        chk("done_pulse", done1, 1);
        chk("busy_done", busy1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        c1 = '0; c2 = '0;
        mem1.MEM_ACK = 1'b0; mem1.MEM_RDATA = '0;
        mem2.MEM_ACK = 1'b0; mem2.MEM_RDATA = '0;
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;

        // Reset state
        c1.r1_sel = 1'b1; c1.op2_sel = 3'd5;
        #1;
        chk("rst_pc", pc1, 32'h0000_1000);
        chk("rst_ir", ir1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_req", mem1.MEM_REQ, 0);
        chk("rst_done", done1, 0);
        chk("rst_addr", mem1.MEM_ADDR, 0);
        chk("rst_we", mem1.MEM_WE, 0);
        chk("rst_zero", zero1, 1);

        // Fetch with 3 wait states; loads during BUSY must be ignored
        c1 = '0; c1.ma_sel = 2'd2; c1.mem_rd = 1'b1;
        sb_push(1'b0, 26'h1000, 32'h0);
        tick();
        c1 = '0; c1.pc_load = 1'b1; c1.ir_load = 1'b1;
        c1.op1_sel = 1'b1; c1.op2_sel = 3'd4; c1.alu_op = 4'd1; c1.sp_load = 1'b1;
        do_txn(3, 32'h2041_0005);
        chk("pc_stall", pc1, 32'h0000_1000);
        chk("ir_stall", ir1, 0);

        // DONE cycle: IR load, PC+1 and a new fetch all accepted together
        c1 = '0; c1.ir_load = 1'b1; c1.pc_load = 1'b1; c1.pc_sel = 2'd0;
        c1.ma_sel = 2'd2; c1.mem_rd = 1'b1;
        sb_push(1'b0, 26'h1000, 32'h0);
        tick();
        c1 = '0;
        chk("ir_fetch1", ir1, 32'h2041_0005);
        chk("pc_inc", pc1, 32'h0000_1001);
        chk("done_low", done1, 0);
        do_txn(1, 32'h0042_11C0);

        // Branch with old IR imm=5, and IR load in the same step
        c1 = '0; c1.ir_load = 1'b1; c1.pc_load = 1'b1; c1.pc_sel = 2'd1;
        tick();
        chk("ir_fetch2", ir1, 32'h0042_11C0);
        chk("pc_branch", pc1, 32'h0000_1007);

        // r2 <= 0 + shamt(7), addressed via rd field
        c1 = '0; c1.r1_sel = 1'b1; c1.op2_sel = 3'd3; c1.rf_we = 1'b1; c1.wa_sel = 2'd1;
        tick();
        // PC <= r2 (7) while r2 <= r2+1 in the same cycle
        c1 = '0; c1.pc_load = 1'b1; c1.pc_sel = 2'd2; c1.rf_we = 1'b1; c1.wa_sel = 2'd0;
        c1.op2_sel = 3'd4;
        tick();
        chk("rf_old_read", pc1, 32'h0000_0007);
        c1 = '0; c1.pc_load = 1'b1; c1.pc_sel = 2'd2;
        tick();
        chk("rf_new_read", pc1, 32'h0000_0008);

        c1 = '0; c1.ma_sel = 2'd2; c1.mem_rd = 1'b1;
        sb_push(1'b0, 26'h8, 32'h0);
        tick();
        c1 = '0;
        do_txn(0, 32'h0042_FFFF);
        c1 = '0; c1.ir_load = 1'b1;
        tick();
        chk("ir_fetch3", ir1, 32'h0042_FFFF);

        // r2 + sext(0xFFFF) = 7 used as write address, R1 (8) as write data
        c1 = '0; c1.op2_sel = 3'd1; c1.ma_sel = 2'd0; c1.mem_wr = 1'b1; c1.md_sel = 1'b1;
        #1;
        chk("zero_add_neg", zero1, 0);
        sb_push(1'b1, 26'h7, 32'h8);
        tick();
        c1 = '0;
        do_txn(2, 32'h0);

        // r0 write is discarded
        c1 = '0; c1.r1_sel = 1'b1; c1.op2_sel = 3'd4; c1.rf_we = 1'b1; c1.wa_sel = 2'd3;
        tick();
        c1 = '0; c1.r1_sel = 1'b1; c1.op2_sel = 3'd5;
        #1;
        chk("r0_reads_zero", zero1, 1);
        c1 = '0; c1.op2_sel = 3'd1; c1.alu_op = 4'd7;
        #1;
        chk("slt_8_lt_m1", zero1, 1);
        c1 = '0; c1.r1_sel = 1'b1; c1.op2_sel = 3'd4; c1.alu_op = 4'd7;
        #1;
        chk("slt_0_lt_1", zero1, 0);
        c1 = '0; c1.op2_sel = 3'd0; c1.alu_op = 4'd1;
        #1;
        chk("sub_self", zero1, 1);

        // ACK while idle is ignored
        c1 = '0; mem1.MEM_ACK = 1'b1;
        tick();
        mem1.MEM_ACK = 1'b0;
        chk("idle_ack_busy", busy1, 0);
        chk("idle_ack_done", done1, 0);

        // Stack push: SP-1, then write at SP while SP decrements again
        c1 = '0; c1.op1_sel = 1'b1; c1.op2_sel = 3'd4; c1.alu_op = 4'd1; c1.sp_load = 1'b1;
        tick();
        c1.ma_sel = 2'd1; c1.mem_wr = 1'b1; c1.md_sel = 1'b0;
        sb_push(1'b1, 26'h3FF_FFFE, 32'h8);
        tick();
        c1 = '0;
        do_txn(1, 32'h0);

        // RD and WR together: write wins
        c1 = '0; c1.r1_sel = 1'b1; c1.md_sel = 1'b1; c1.ma_sel = 2'd1;
        c1.mem_rd = 1'b1; c1.mem_wr = 1'b1;
        sb_push(1'b1, 26'h3FF_FFFD, 32'h0);
        tick();
        c1 = '0;
        do_txn(0, 32'h0);

        // Reset during WAIT
        c1 = '0; c1.ma_sel = 2'd2; c1.mem_rd = 1'b1;
        sb_push(1'b0, 26'h8, 32'h0);
        tick();
        c1 = '0;
        sb_check();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rstw_req", mem1.MEM_REQ, 0);
        chk("rstw_busy", busy1, 0);
        chk("rstw_done", done1, 0);
        chk("rstw_pc", pc1, 32'h0000_1000);
        chk("rstw_ir", ir1, 0);
        tick();
        chk("rstw_no_done", done1, 0);
        c1.ir_load = 1'b1;
        tick();
        c1 = '0;
        chk("mdr_reset", ir1, 0);

        // 64-bit, 8-register instance
        c2 = '0; c2.ma_sel = 2'd2; c2.mem_rd = 1'b1;
        tick();
        c2 = '0;
        chk("w_req", mem2.MEM_REQ, 1);
        chk("w_fetch_addr", mem2.MEM_ADDR, 64'h1000);
        mem2.MEM_ACK = 1'b1; mem2.MEM_RDATA = 64'hDEAD_BEEF_00E0_0028;
        tick();
        mem2.MEM_ACK = 1'b0; mem2.MEM_RDATA = '0;
        chk("w_done", done2, 1);
        c2.ir_load = 1'b1;
        tick();
        chk("w_ir", ir2, 32'h00E0_0028);

        c2 = '0; c2.r1_sel = 1'b1; c2.op2_sel = 3'd4; c2.rf_we = 1'b1; c2.wa_sel = 2'd2;
        tick();
        c2 = '0; c2.op2_sel = 3'd2; c2.alu_op = 4'd5; c2.ma_sel = 2'd0; c2.mem_rd = 1'b1;
        #1;
        chk("w_sll_zero", zero2, 0);
        tick();
        c2 = '0;
        chk("w_sll40", mem2.MEM_ADDR, 64'd1 << 40);
        mem2.MEM_ACK = 1'b1;
        tick();
        mem2.MEM_ACK = 1'b0;
        chk("w_done2", done2, 1);

        c2 = '0; c2.r1_sel = 1'b1; c2.op2_sel = 3'd5; c2.alu_op = 4'd4;
        c2.rf_we = 1'b1; c2.wa_sel = 2'd2;
        tick();
        c2 = '0; c2.pc_load = 1'b1; c2.pc_sel = 2'd2;
        tick();
        chk("w_pc_ones", pc2, {64{1'b1}});
        c2.pc_sel = 2'd0;
        tick();
        c2 = '0;
        chk("w_pc_wrap", pc2, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
